huff_encoder: RTL and testbench

Huffman code lookup stage directly upstream of `packer`. Accepts one 8-bit character at a time, looks up its code and length in a loadable 256-entry code table, and presents `code`/`bits`/`code_done`/`last_char` to `packer`, holding them until `packer` accepts with `input_enable`. The table is loaded through a write port from the control path before a stream starts.

---
 rtl/huff_pkg.sv | 35 +++
 rtl/huff_encoder_code_table.sv | 38 +++
 rtl/huff_encoder.sv | 114 +++++++++++
 tb/tb_huff_encoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/huff_pkg.sv
// Shared types and constants for the Huffman encode path (encoder and packer).
package huff_pkg;

    localparam int CHAR_W    = 8;
    localparam int CODE_W    = 64;
    localparam int BITS_W    = 7;
    localparam int MAX_BITS  = 64;
    localparam int TBL_DEPTH = 1 << CHAR_W;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [BITS_W-1:0] bits;
    } code_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_PRESENT,
        ST_DONE
    } enc_state_t;

    function automatic logic [BITS_W-1:0] clamp_bits(input logic [BITS_W-1:0] b);
        return (b > BITS_W'(MAX_BITS)) ? BITS_W'(MAX_BITS) : b;
    endfunction

    // A full-width shift would wrap, so lengths of MAX_BITS or more pass the code untouched.
    function automatic logic [CODE_W-1:0] mask_code(input logic [CODE_W-1:0] code,
                                                   input logic [BITS_W-1:0] bits);
        if (bits >= BITS_W'(MAX_BITS)) begin
            return code;
        end
        return code & ((CODE_W'(1) << bits) - CODE_W'(1));
    endfunction

endpackage

// File: rtl/huff_encoder_code_table.sv
// Loadable character-to-code table: clamped write port, combinational read port.
module code_table
    import huff_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CHAR_W-1:0] wr_addr,
    input  logic [CODE_W-1:0] wr_code,
    input  logic [BITS_W-1:0] wr_bits,
    input  logic [CHAR_W-1:0] rd_addr,
    output code_entry_t       rd_entry
);

    code_entry_t mem_q [TBL_DEPTH];
    code_entry_t wr_entry_d;

    always_comb begin
        wr_entry_d.code = wr_code;
        wr_entry_d.bits = clamp_bits(wr_bits);
    end

    // NOTE: this array is reset on purpose -- after rst every character must read as unmapped,
    // which forces flops instead of a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
            mem_q[wr_addr] <= wr_entry_d;
        end
    end

    assign rd_entry = mem_q[rd_addr];

endmodule

// File: rtl/huff_encoder.sv
// Huffman code lookup stage: one character in, one masked code/length presented to packer.
module huff_encoder
    import huff_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              tbl_wr_en,
    input  logic [CHAR_W-1:0] tbl_wr_addr,
    input  logic [CODE_W-1:0] tbl_wr_code,
    input  logic [BITS_W-1:0] tbl_wr_bits,
    input  logic              char_valid,
    input  logic [CHAR_W-1:0] char_data,
    input  logic              char_last,
    output logic              char_ready,
    input  logic              input_enable,
    output logic              code_done,
    output logic [CODE_W-1:0] code,
    output logic [BITS_W-1:0] bits,
    output logic              last_char,
    output logic              stream_done,
    output logic              err_unmapped
);

    enc_state_t        state_q, state_d;
    logic [CHAR_W-1:0] char_q, char_d;
    logic              last_flag_q, last_flag_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [BITS_W-1:0] bits_q, bits_d;
    logic              last_char_q, last_char_d;
    logic              err_q, err_d;
    logic              tbl_we;
    code_entry_t       entry;

    // The table is frozen while a code is in flight so the presented entry stays coherent.
    assign tbl_we = tbl_wr_en && (state_q == ST_IDLE || state_q == ST_DONE);

    code_table u_table (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (tbl_we),
        .wr_addr  (tbl_wr_addr),
        .wr_code  (tbl_wr_code),
        .wr_bits  (tbl_wr_bits),
        .rd_addr  (char_q),
        .rd_entry (entry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            char_q      <= '0;
            last_flag_q <= 1'b0;
            code_q      <= '0;
            bits_q      <= '0;
            last_char_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            char_q      <= char_d;
            last_flag_q <= last_flag_d;
            code_q      <= code_d;
            bits_q      <= bits_d;
            last_char_q <= last_char_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (char_valid) state_d = ST_LOOKUP;
            ST_LOOKUP:  state_d = ST_PRESENT;
            ST_PRESENT: if (input_enable) state_d = last_flag_q ? ST_DONE : ST_IDLE;
            ST_DONE:    if (start) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        char_d      = char_q;
        last_flag_d = last_flag_q;
        code_d      = code_q;
        bits_d      = bits_q;
        last_char_d = last_char_q;
        err_d       = start ? 1'b0 : err_q;
        if (state_q == ST_IDLE && char_valid) begin
            char_d      = char_data;
            last_flag_d = char_last;
        end
        // Unmapped entries still go out (code 0, bits 0) so last_char reaches packer.
        if (state_q == ST_LOOKUP) begin
            code_d      = mask_code(entry.code, entry.bits);
            bits_d      = entry.bits;
            last_char_d = last_flag_q;
            if (entry.bits == '0) begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        char_ready  = (state_q == ST_IDLE);
        code_done   = (state_q == ST_PRESENT);
        stream_done = (state_q == ST_DONE);
    end

    assign code         = code_q;
    assign bits         = bits_q;
    assign last_char    = last_char_q;
    assign err_unmapped = err_q;

endmodule

// File: tb/tb_huff_encoder.sv
// Directed self-checking bench for huff_encoder.
module tb_huff_encoder;
    import huff_pkg::*;

    logic              clk;
    logic              rst;
    logic              start;
    logic              tbl_wr_en;
    logic [CHAR_W-1:0] tbl_wr_addr;
    logic [CODE_W-1:0] tbl_wr_code;
    logic [BITS_W-1:0] tbl_wr_bits;
    logic              char_valid;
    logic [CHAR_W-1:0] char_data;
    logic              char_last;
    logic              char_ready;
    logic              input_enable;
    logic              code_done;
    logic [CODE_W-1:0] code;
    logic [BITS_W-1:0] bits;
    logic              last_char;
    logic              stream_done;
    logic              err_unmapped;

    int n_cmp = 0;
    int n_err = 0;

    huff_encoder dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .tbl_wr_en    (tbl_wr_en),
        .tbl_wr_addr  (tbl_wr_addr),
        .tbl_wr_code  (tbl_wr_code),
        .tbl_wr_bits  (tbl_wr_bits),
        .char_valid   (char_valid),
        .char_data    (char_data),
        .char_last    (char_last),
        .char_ready   (char_ready),
        .input_enable (input_enable),
        .code_done    (code_done),
        .code         (code),
        .bits         (bits),
        .last_char    (last_char),
        .stream_done  (stream_done),
        .err_unmapped (err_unmapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end at a falling edge, so inputs change away from the rising edge.
    task automatic tbl_write(input logic [CHAR_W-1:0] a, input logic [CODE_W-1:0] c,
                             input logic [BITS_W-1:0] b);
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = a;
        tbl_wr_code = c;
        tbl_wr_bits = b;
        @(negedge clk);
        tbl_wr_en   = 1'b0;
    endtask

    // Ends in PRESENT: accept edge, LOOKUP edge.
    task automatic send_char(input logic [CHAR_W-1:0] d, input logic l, input string tag);
        char_valid = 1'b1;
        char_data  = d;
        char_last  = l;
        @(negedge clk);
        char_valid = 1'b0;
        char_last  = 1'b0;
        check({tag, "_lookup_ready"}, 64'(char_ready), 64'd0);
        @(negedge clk);
        check({tag, "_code_done"}, 64'(code_done), 64'd1);
    endtask

    task automatic accept();
        input_enable = 1'b1;
        @(negedge clk);
        input_enable = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        tbl_wr_en    = 1'b0;
        tbl_wr_addr  = '0;
        tbl_wr_code  = '0;
        tbl_wr_bits  = '0;
        char_valid   = 1'b0;
        char_data    = '0;
        char_last    = 1'b0;
        input_enable = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_char_ready", 64'(char_ready), 64'd1);
        check("rst_code_done", 64'(code_done), 64'd0);
        check("rst_code", code, 64'd0);
        check("rst_bits", 64'(bits), 64'd0);
        check("rst_last_char", 64'(last_char), 64'd0);
        check("rst_stream_done", 64'(stream_done), 64'd0);
        check("rst_err", 64'(err_unmapped), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single-cycle presentation with input_enable held high.
        tbl_write(8'h41, 64'd17, 7'd5);
        input_enable = 1'b1;
        send_char(8'h41, 1'b0, "t1");
        check("t1_code", code, 64'd17);
        check("t1_bits", 64'(bits), 64'd5);
        check("t1_last_char", 64'(last_char), 64'd0);
        @(negedge clk);
        input_enable = 1'b0;
        check("t1_done_fell", 64'(code_done), 64'd0);
        check("t1_ready_rose", 64'(char_ready), 64'd1);

        // Back-pressure: outputs hold for 5 cycles.
        tbl_write(8'h42, 64'd38269, 7'd16);
        send_char(8'h42, 1'b0, "t2");
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_done", 64'(code_done), 64'd1);
            check("t2_hold_code", code, 64'd38269);
            check("t2_hold_bits", 64'(bits), 64'd16);
            check("t2_hold_ready", 64'(char_ready), 64'd0);
            @(negedge clk);
        end
        accept();
        check("t2_done_fell", 64'(code_done), 64'd0);
        check("t2_ready_rose", 64'(char_ready), 64'd1);

        // Mask: low 11 bits of 0x...F5B5 = 0x5B5 = 1461.
        tbl_write(8'h43, 64'hFFFF_FFFF_FFFF_F5B5, 7'd11);
        send_char(8'h43, 1'b0, "t3");
        check("t3_code", code, 64'd1461);
        check("t3_bits", 64'(bits), 64'd11);
        accept();

        // Unmapped last character, DONE, and restart.
        send_char(8'h44, 1'b1, "t4");
        check("t4_code", code, 64'd0);
        check("t4_bits", 64'(bits), 64'd0);
        check("t4_last_char", 64'(last_char), 64'd1);
        check("t4_err", 64'(err_unmapped), 64'd1);
        accept();
        check("t4_stream_done", 64'(stream_done), 64'd1);
        check("t4_ready_done", 64'(char_ready), 64'd0);
        check("t4_code_done_done", 64'(code_done), 64'd0);
        char_valid = 1'b1;
        char_data  = 8'h41;
        @(negedge clk);
        char_valid = 1'b0;
        check("t4_valid_ignored", 64'(stream_done), 64'd1);
        check("t4_err_sticky", 64'(err_unmapped), 64'd1);
        pulse_start();
        check("t4_start_idle", 64'(char_ready), 64'd1);
        check("t4_start_stream_done", 64'(stream_done), 64'd0);
        check("t4_start_err", 64'(err_unmapped), 64'd0);

        // Writes during PRESENT are dropped.
        send_char(8'h41, 1'b0, "t5a");
        tbl_write(8'h45, 64'd463, 7'd9);
        check("t5_present_held", code, 64'd17);
        accept();
        send_char(8'h45, 1'b0, "t5b");
        check("t5_dropped_bits", 64'(bits), 64'd0);
        check("t5_dropped_code", code, 64'd0);
        check("t5_dropped_err", 64'(err_unmapped), 64'd1);
        accept();
        pulse_start();
        check("t5_idle_start_ready", 64'(char_ready), 64'd1);
        check("t5_idle_start_err", 64'(err_unmapped), 64'd0);

        // Write and accept of the same address in one IDLE cycle: new entry wins.
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = 8'h45;
        tbl_wr_code = 64'd463;
        tbl_wr_bits = 7'd9;
        send_char(8'h45, 1'b0, "t5c");
        tbl_wr_en = 1'b0;
        check("t5_same_cycle_code", code, 64'd463);
        check("t5_same_cycle_bits", 64'(bits), 64'd9);
        accept();

        // Length clamp to 64 with all code bits passing.
        tbl_write(8'h46, 64'hFFFF_FFFF_FFFF_FFFF, 7'd100);
        send_char(8'h46, 1'b0, "t6");
        check("t6_clamp_bits", 64'(bits), 64'd64);
        check("t6_full_code", code, 64'hFFFF_FFFF_FFFF_FFFF);
        accept();

        // Asynchronous reset in PRESENT clears state and table.
        send_char(8'h41, 1'b0, "t7");
        rst = 1'b1;
        #1;
        check("t7_async_done", 64'(code_done), 64'd0);
        check("t7_async_ready", 64'(char_ready), 64'd1);
        check("t7_async_code", code, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_char(8'h41, 1'b0, "t7a");
        check("t7_cleared_41", 64'(bits), 64'd0);
        accept();
        send_char(8'h43, 1'b0, "t7b");
        check("t7_cleared_43", 64'(bits), 64'd0);
        check("t7_cleared_43_code", code, 64'd0);
        accept();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
